uart_tx_scheduler: RTL

// - Shares the single UART transmit FIFO between the game modules that publish link bytes:

---
 rtl/game_pkg.sv | 31 +++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 43 ++++
 rtl/uart_tx_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the game link transmit path.
//   tx_state_t     : states of the UART transmit scheduler FSM
//   CH_*           : fixed channel indices of the byte producers
//   UART_N_CH      : number of producers sharing the UART transmit FIFO
//   sat_add8()     : 8-bit saturating add used by the overwrite counter
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_ISSUE,
    TX_GAP
  } tx_state_t;

  localparam int CH_GAME_STATE = 0;
  localparam int CH_GLOVES     = 1;
  localparam int CH_MOUSE      = 2;
  localparam int CH_SCORE      = 3;

  localparam int UART_N_CH = 4;

  // Adds a small per-cycle increment and clamps at 8'hFF.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {5'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant selection. Picks the first set bit of the
// pending mask strictly after the last-granted index, wrapping N_CH-1 -> 0.
//   i_pending      in  N_CH    request mask
//   i_rr_ptr       in  IDX_W   index granted last time
//   o_grant        out IDX_W   selected channel (0 when nothing pending)
//   o_grant_valid  out 1       at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         i_pending,
  input  logic [$clog2(N_CH)-1:0] i_rr_ptr,
  output logic [$clog2(N_CH)-1:0] o_grant,
  output logic                    o_grant_valid
);

  localparam int IDX_W = $clog2(N_CH);

  // w_cand[k] is the channel examined at search distance k+1 from the pointer;
  // the modulo keeps non-power-of-two channel counts from wrapping at 2**IDX_W.
  logic [IDX_W-1:0] w_cand [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
      assign w_cand[gi] = IDX_W'((int'(i_rr_ptr) + gi + 1) % N_CH);
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest pending one wins.
  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (i_pending[w_cand[k]]) begin
        o_grant       = w_cand[k];
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmit FIFO between the game byte producers. Each channel
// presents a level byte; a change against the last byte sent queues it (one
// slot per channel, latest value wins) and queued bytes are written round-robin
// as single-cycle wr_uart strobes separated by at least GAP_CYCLES idle clocks.
//
// Ports
//   clk      in   1       system clock
//   rst      in   1       asynchronous active-low reset
//   ch_data  in   N_CH*8  channel i byte is ch_data[8*i +: 8]
//   tx_full  in   1       UART TX FIFO full; blocks new grants
//   w_data   out  8       byte to the UART, valid while wr_uart=1
//   wr_uart  out  1       one-cycle write strobe
//   pending  out  N_CH    per-channel byte queued and not yet written
//   ovr_cnt  out  8       saturating count of queued bytes replaced before send
//
// Build option
//   UART_TX_REFRESH_EN : when defined, every REFRESH_CYCLES clocks all idle
//                        channels re-queue their current byte so a late peer
//                        resynchronises. Undefined: bytes go out only on change.
// -----------------------------------------------------------------------------
module uart_tx_scheduler
  import game_pkg::*;
#(
  parameter int N_CH           = UART_N_CH,
  parameter int GAP_CYCLES     = 16,
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*8-1:0] ch_data,
  input  logic              tx_full,
  output logic [7:0]        w_data,
  output logic              wr_uart,
  output logic [N_CH-1:0]   pending,
  output logic [7:0]        ovr_cnt
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_t         r_state;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [IDX_W-1:0]  r_rr;
  logic [7:0]        r_w_data;
  logic              r_wr_uart;
  logic [7:0]        r_ovr_cnt;

  logic [N_CH-1:0]   w_pending;
  logic [N_CH-1:0]   w_ovr_hit;
  logic [7:0]        w_hold [N_CH];
  logic [3:0]        w_ovr_inc;
  logic [IDX_W-1:0]  w_grant;
  logic              w_grant_valid;
  logic              w_grant_fire;
  logic              w_refresh;

  rr_arbiter #(
    .N_CH(N_CH)
  ) u_rr_arbiter (
    .i_pending     (w_pending),
    .i_rr_ptr      (r_rr),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid)
  );

  // A grant may also fire on the last GAP clock so consecutive writes are
  // exactly GAP_CYCLES+1 clocks apart instead of losing a cycle to IDLE.
  assign w_grant_fire = w_grant_valid && !tx_full &&
                        ((r_state == TX_IDLE) ||
                         ((r_state == TX_GAP) && (r_gap_cnt == GAP_W'(GAP_CYCLES - 1))));

`ifdef UART_TX_REFRESH_EN
  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  logic [REF_W-1:0] r_ref_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ref_cnt <= '0;
    end else if (r_ref_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  assign w_refresh = (r_ref_cnt == REF_W'(REFRESH_CYCLES - 1));
`else
  assign w_refresh = 1'b0;
`endif

  // Per-channel change detection and single-entry queue.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [7:0] w_ch;
      logic       w_issue_ch;
      logic [7:0] r_hold;
      logic [7:0] r_last_sent;
      logic       r_pend;

      assign w_ch       = ch_data[8*gi +: 8];
      assign w_issue_ch = (r_state == TX_ISSUE) && (r_rr == IDX_W'(gi));
      // The channel being written this cycle may take a new byte without
      // counting it as an overwrite: the old byte is already on its way out.
      assign w_ovr_hit[gi] = r_pend && !w_issue_ch && (w_ch != r_hold);
      assign w_hold[gi]    = r_hold;
      assign w_pending[gi] = r_pend;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_hold      <= '0;
          r_last_sent <= '0;
          r_pend      <= 1'b0;
        end else begin
          if (w_grant_fire && (w_grant == IDX_W'(gi))) begin
            r_last_sent <= r_hold;
          end
          if (w_issue_ch) begin
            if (w_ch != r_hold) begin
              r_hold <= w_ch;
            end else begin
              r_pend <= 1'b0;
            end
          end else if (r_pend) begin
            if (w_ch != r_hold) begin
              r_hold <= w_ch;
            end
          end else if ((w_ch != r_last_sent) || w_refresh) begin
            r_hold <= w_ch;
            r_pend <= 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_ovr_inc = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_ovr_inc = w_ovr_inc + 4'(w_ovr_hit[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= TX_IDLE;
      r_gap_cnt <= '0;
      r_rr      <= IDX_W'(N_CH - 1);
      r_w_data  <= '0;
      r_wr_uart <= 1'b0;
      r_ovr_cnt <= '0;
    end else begin
      r_ovr_cnt <= sat_add8(r_ovr_cnt, w_ovr_inc);
      r_wr_uart <= 1'b0;
      if (w_grant_fire) begin
        r_state   <= TX_ISSUE;
        r_w_data  <= w_hold[w_grant];
        r_wr_uart <= 1'b1;
        r_rr      <= w_grant;
      end else begin
        case (r_state)
          TX_IDLE: begin
            r_state <= TX_IDLE;
          end
          TX_ISSUE: begin
            r_state   <= TX_GAP;
            r_gap_cnt <= '0;
          end
          TX_GAP: begin
            if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
              r_state <= TX_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= TX_IDLE;
          end
        endcase
      end
    end
  end

  assign w_data  = r_w_data;
  assign wr_uart = r_wr_uart;
  assign pending = w_pending;
  assign ovr_cnt = r_ovr_cnt;

endmodule
